// File: rtl/note_mono_midi_tx_if.sv
// Byte-stream handshake between the mono note-to-MIDI encoder and the MIDI UART.
// A byte transfers on any clock edge where tx_valid && tx_ready; the master holds
// tx_data/tx_valid stable until that edge, and tx_ready may stall indefinitely.
interface note_mono_midi_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/note_mono_midi_tx.sv
// Re-encodes the resolved mono note/gate line as MIDI Note On / Note Off bytes.
// Optional feature: define MIDI_RUNNING_STATUS_EN for running status and 0x9n-vel-0 Note Offs.
module note_mono_midi_tx #(
    parameter logic [6:0] REL_VEL = 7'h40
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [6:0]                  in_note,
    input  logic                        in_gate,
    input  logic [6:0]                  velocity,
    input  logic [3:0]                  channel,
    note_mono_midi_tx_if.master         tx,
    output logic                        busy,
    output logic [1:0]                  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STATUS = 2'd1,
        DATA1  = 2'd2,
        DATA2  = 2'd3
    } state_t;

    state_t     state_q;
    state_t     state_d;

    // What the MIDI OUT receiver currently believes is sounding.
    logic       sent_gate_q;
    logic [6:0] sent_note_q;
    logic       pend_off_q;
    logic [6:0] pend_note_q;

    // Bytes of the message in flight, frozen at message start.
    logic [7:0] status_q;
    logic [6:0] note_q;
    logic [7:0] third_q;

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] last_status_q;
`endif

    logic       start;
    logic       is_on;
    logic       set_pend;
    logic [6:0] msg_note;
    logic [6:0] vel_clamped;
    logic [7:0] msg_status;
    logic [7:0] msg_third;
    logic       skip_status;
    logic       hs;

    // Event priority: queued Note Off, gate rise, legato change, gate fall.
    always_comb begin
        start    = 1'b0;
        is_on    = 1'b0;
        set_pend = 1'b0;
        msg_note = in_note;
        if (pend_off_q) begin
            start    = 1'b1;
            msg_note = pend_note_q;
        end else if (in_gate && !sent_gate_q) begin
            start = 1'b1;
            is_on = 1'b1;
        end else if (in_gate && (in_note != sent_note_q)) begin
            start    = 1'b1;
            is_on    = 1'b1;
            set_pend = 1'b1;
        end else if (!in_gate && sent_gate_q) begin
            start    = 1'b1;
            msg_note = sent_note_q;
        end
    end

    // A zero velocity Note On would read as a Note Off downstream.
    assign vel_clamped = (velocity == 7'd0) ? 7'd1 : velocity;

    always_comb begin
        msg_status  = 8'h00;
        msg_third   = 8'h00;
        skip_status = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
        msg_status  = {4'h9, channel};
        msg_third   = is_on ? {1'b0, vel_clamped} : 8'h00;
        skip_status = (msg_status == last_status_q);
`else
        msg_status  = is_on ? {4'h9, channel} : {4'h8, channel};
        msg_third   = is_on ? {1'b0, vel_clamped} : {1'b0, REL_VEL};
`endif
    end

    always_comb begin
        state_d     = state_q;
        tx.tx_valid = (state_q != IDLE);
        tx.tx_data  = 8'h00;
        busy        = (state_q != IDLE);
        hs          = (state_q != IDLE) && tx.tx_ready;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = skip_status ? DATA1 : STATUS;
                end
            end
            STATUS: begin
                tx.tx_data = status_q;
                if (hs) begin
                    state_d = DATA1;
                end
            end
            DATA1: begin
                tx.tx_data = {1'b0, note_q};
                if (hs) begin
                    state_d = DATA2;
                end
            end
            DATA2: begin
                tx.tx_data = third_q;
                if (hs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Receiver belief is updated at message start; later input changes collapse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sent_gate_q <= 1'b0;
            sent_note_q <= 7'd0;
            pend_off_q  <= 1'b0;
            pend_note_q <= 7'd0;
            status_q    <= 8'h00;
            note_q      <= 7'd0;
            third_q     <= 8'h00;
        end else if ((state_q == IDLE) && start) begin
            status_q <= msg_status;
            note_q   <= msg_note;
            third_q  <= msg_third;
            if (pend_off_q) begin
                pend_off_q <= 1'b0;
            end else if (is_on) begin
                sent_gate_q <= 1'b1;
                sent_note_q <= in_note;
                if (set_pend) begin
                    pend_off_q  <= 1'b1;
                    pend_note_q <= sent_note_q;
                end
            end else begin
                sent_gate_q <= 1'b0;
            end
        end
    end

`ifdef MIDI_RUNNING_STATUS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_status_q <= 8'h00;
        end else if ((state_q == STATUS) && hs) begin
            last_status_q <= status_q;
        end
    end
`endif

endmodule

// File: tb/tb_note_mono_midi_tx.sv
// Directed bench for note_mono_midi_tx: a byte-queue model of the MIDI stream checked
// every cycle, plus hand-computed byte sequences for each scenario.
module tb_note_mono_midi_tx;

    localparam logic [6:0] REL_VEL = 7'h40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] in_note = 7'd0;
    logic       in_gate = 1'b0;
    logic [6:0] velocity = 7'd100;
    logic [3:0] channel = 4'd0;
    logic       busy;
    logic [1:0] dbg_state;

    note_mono_midi_tx_if tx_if();

    note_mono_midi_tx #(.REL_VEL(REL_VEL)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_note   (in_note),
        .in_gate   (in_gate),
        .velocity  (velocity),
        .channel   (channel),
        .tx        (tx_if),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    logic [7:0] model_q[$];

    logic       live = 1'b0;
    logic       ms_gate;
    logic [6:0] ms_note;
    logic       mp_off;
    logic [6:0] mp_note;
    logic [7:0] m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check($sformatf("%s_b%0d", name, i), {24'h0, log_q[i]}, {24'h0, exp_q[i]});
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: append the bytes a message puts on the wire.
    function automatic void push_msg(input logic on, input logic [6:0] note);
        logic [7:0] st;
        logic [7:0] third;
        if (on) begin
            st    = 8'h90 + {4'h0, channel};
            third = (velocity == 7'd0) ? 8'h01 : {1'b0, velocity};
        end else begin
`ifdef MIDI_RUNNING_STATUS_EN
            st    = 8'h90 + {4'h0, channel};
            third = 8'h00;
`else
            st    = 8'h80 + {4'h0, channel};
            third = {1'b0, REL_VEL};
`endif
        end
`ifdef MIDI_RUNNING_STATUS_EN
        if (st != m_last) model_q.push_back(st);
`else
        model_q.push_back(st);
`endif
        model_q.push_back({1'b0, note});
        model_q.push_back(third);
    endfunction

    always @(posedge clk) begin
        logic [7:0] b;
        if (rst) begin
            model_q.delete();
            ms_gate = 1'b0;
            ms_note = 7'd0;
            mp_off  = 1'b0;
            mp_note = 7'd0;
            m_last  = 8'h00;
            live    = 1'b1;
        end else if (model_q.size() == 0) begin
            if (mp_off) begin
                push_msg(1'b0, mp_note);
                mp_off = 1'b0;
            end else if (in_gate && !ms_gate) begin
                push_msg(1'b1, in_note);
                ms_gate = 1'b1;
                ms_note = in_note;
            end else if (in_gate && in_note != ms_note) begin
                push_msg(1'b1, in_note);
                mp_off  = 1'b1;
                mp_note = ms_note;
                ms_note = in_note;
            end else if (!in_gate && ms_gate) begin
                push_msg(1'b0, ms_note);
                ms_gate = 1'b0;
            end
        end else if (tx_if.tx_ready) begin
            b = model_q.pop_front();
            if (b[7]) m_last = b;
        end
    end

    // scoreboard: per-cycle compare and accepted-byte log
    always @(negedge clk) begin
        if (live) begin
            check("tx_valid", {31'h0, tx_if.tx_valid}, {31'h0, model_q.size() > 0});
            check("busy", {31'h0, busy}, {31'h0, model_q.size() > 0});
            if (model_q.size() > 0) begin
                check("tx_data", {24'h0, tx_if.tx_data}, {24'h0, model_q[0]});
            end
            if (!rst && tx_if.tx_valid && tx_if.tx_ready) log_q.push_back(tx_if.tx_data);
        end
    end

    logic [7:0] held;
    int         busy_n;

    initial begin
        tx_if.tx_ready = 1'b1;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        check("rst_valid", {31'h0, tx_if.tx_valid}, 32'h0);
        check("rst_data", {24'h0, tx_if.tx_data}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);

        // gate rise
        log_q.delete();
        in_note = 7'd60;
        velocity = 7'd100;
        channel = 4'd0;
        in_gate = 1'b1;
        busy_n = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (busy) busy_n++;
        end
        check("on_busy_cycles", busy_n, 32'd3);
        exp_q = '{8'h90, 8'h3c, 8'h64};
        check_log("note_on");

        // gate fall
        log_q.delete();
        in_gate = 1'b0;
        cyc(8);
`ifdef MIDI_RUNNING_STATUS_EN
        exp_q = '{8'h3c, 8'h00};
`else
        exp_q = '{8'h80, 8'h3c, 8'h40};
`endif
        check_log("note_off");

        // legato 60 -> 64, then release
        log_q.delete();
        in_note = 7'd60;
        in_gate = 1'b1;
        cyc(8);
        in_note = 7'd64;
        cyc(14);
        in_gate = 1'b0;
        cyc(10);
`ifdef MIDI_RUNNING_STATUS_EN
        exp_q = '{8'h3c, 8'h64, 8'h40, 8'h64, 8'h3c, 8'h00, 8'h40, 8'h00};
`else
        exp_q = '{8'h90, 8'h3c, 8'h64, 8'h90, 8'h40, 8'h64,
                  8'h80, 8'h3c, 8'h40, 8'h80, 8'h40, 8'h40};
`endif
        check_log("legato");

        // stall mid-message with velocity 0
        log_q.delete();
        velocity = 7'd0;
        in_note = 7'h32;
        in_gate = 1'b1;
        cyc(2);
        tx_if.tx_ready = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
        held = 8'h01;
`else
        held = 8'h32;
`endif
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("stall_data", {24'h0, tx_if.tx_data}, {24'h0, held});
            check("stall_valid", {31'h0, tx_if.tx_valid}, 32'h1);
        end
        tx_if.tx_ready = 1'b1;
        cyc(6);
        in_gate = 1'b0;
        cyc(8);
`ifdef MIDI_RUNNING_STATUS_EN
        exp_q = '{8'h32, 8'h01, 8'h32, 8'h00};
`else
        exp_q = '{8'h90, 8'h32, 8'h01, 8'h80, 8'h32, 8'h40};
`endif
        check_log("stall_vel0");

        // channel 15, gate falls while the Note On is still going out
        log_q.delete();
        velocity = 7'd100;
        channel = 4'd15;
        in_note = 7'h45;
        in_gate = 1'b1;
        cyc(1);
        in_gate = 1'b0;
        cyc(14);
`ifdef MIDI_RUNNING_STATUS_EN
        exp_q = '{8'h9f, 8'h45, 8'h64, 8'h45, 8'h00};
`else
        exp_q = '{8'h9f, 8'h45, 8'h64, 8'h8f, 8'h45, 8'h40};
`endif
        check_log("ch15_short");

        // reset while in the first data byte
        channel = 4'd0;
        in_note = 7'd60;
        in_gate = 1'b1;
        cyc(2);
        check("pre_rst_state", {30'h0, dbg_state}, 32'd2);
        rst = 1'b1;
        cyc(1);
        check("mid_rst_valid", {31'h0, tx_if.tx_valid}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        log_q.delete();
        cyc(8);
        exp_q = '{8'h90, 8'h3c, 8'h64};
        check_log("after_rst");
        in_gate = 1'b0;
        cyc(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
